// File: rtl/rq_pkg.sv
// Shared types and position-mask helpers for the request scheduler.
// Helpers work on a fixed 16-bit vector; callers zero-extend position.
package rq_pkg;

  localparam int MAXF = 16;

  typedef logic [MAXF-1:0] fvec_t;

  typedef enum logic [1:0] {
    UD_IDLE = 2'b00,
    UD_UP   = 2'b01,
    UD_DOWN = 2'b10
  } ud_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_STOP
  } state_t;

  function automatic fvec_t above_mask(input fvec_t p);
    return ~(p | (p - 1'b1));
  endfunction

  function automatic fvec_t below_mask(input fvec_t p);
    return p - 1'b1;
  endfunction

  function automatic logic onehot_ok(input fvec_t p);
    return (p != '0) && ((p & (p - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/rq_latch.sv
// Pending-request register: sets accumulate, clears take priority.
// Only the scheduler's served floor is ever cleared.
module rq_latch #(
  parameter int FLOORS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] set,
  input  logic [FLOORS-1:0] clr,
  output logic [FLOORS-1:0] pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend | set) & ~clr;
  end

endmodule

// File: rtl/rq_scheduler.sv
// Direction/stop scheduler over latched hall and car requests.
// Invalid position freezes the FSM while requests keep latching.
module rq_scheduler #(
  parameter int FLOORS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] up_req,
  input  logic [FLOORS-1:0] down_req,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] position,
  input  logic              door_done,
  output logic [1:0]        ud_mode,
  output logic              stop_here,
  output logic [FLOORS-1:0] eff_req,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] down_pend,
  output logic [FLOORS-1:0] car_pend,
  output logic              pos_err
);
  import rq_pkg::*;

  localparam logic [FLOORS-1:0] UP_OK =
    {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK =
    {{(FLOORS-1){1'b1}}, 1'b0};

  state_t state, nextState;
  ud_t udMode, nextUd, lastDir, nextLast;
  logic stopHere, posErr;
  logic [FLOORS-1:0] effReq, nextEff;
  logic [FLOORS-1:0] upClr, dnClr, carClr;
  logic [FLOORS-1:0] allPend, above, below;
  fvec_t posW, aboveW, belowW;
  logic posOk, anyAbove, anyBelow, atP;
  logic fwd, back, unusedBits;

  always_comb begin
    posW = '0;
    posW[FLOORS-1:0] = position;
  end

  assign aboveW = above_mask(posW);
  assign belowW = below_mask(posW);
  assign above = aboveW[FLOORS-1:0];
  assign below = belowW[FLOORS-1:0];
  assign posOk = onehot_ok(posW);
  assign unusedBits = ^{aboveW, belowW};

  assign allPend = up_pend | down_pend | car_pend;
  assign anyAbove = |(allPend & above);
  assign anyBelow = |(allPend & below);
  assign atP = |(allPend & position);

  always_comb begin
    nextState = state;
    nextUd = udMode;
    nextLast = lastDir;
    upClr = '0;
    dnClr = '0;
    carClr = '0;
    fwd = 1'b0;
    back = 1'b0;
    if (posOk) begin
      unique case (state)
        S_IDLE: begin
          if (atP) begin
            nextState = S_STOP;
            upClr = position;
            dnClr = position;
            carClr = position;
          end else if (anyAbove && anyBelow) begin
            nextState = (lastDir == UD_UP) ? S_UP : S_DOWN;
            nextUd = lastDir;
          end else if (anyAbove) begin
            nextState = S_UP;
            nextUd = UD_UP;
            nextLast = UD_UP;
          end else if (anyBelow) begin
            nextState = S_DOWN;
            nextUd = UD_DOWN;
            nextLast = UD_DOWN;
          end
        end
        S_UP: begin
          if (|((car_pend | up_pend) & position) ||
              (|(down_pend & position) && !anyAbove)) begin
            nextState = S_STOP;
            carClr = position;
            upClr = position;
            if (!anyAbove) dnClr = position;
          end else if (!anyAbove) begin
            nextState = anyBelow ? S_DOWN : S_IDLE;
            nextUd = anyBelow ? UD_DOWN : UD_IDLE;
            if (anyBelow) nextLast = UD_DOWN;
          end
        end
        S_DOWN: begin
          if (|((car_pend | down_pend) & position) ||
              (|(up_pend & position) && !anyBelow)) begin
            nextState = S_STOP;
            carClr = position;
            dnClr = position;
            if (!anyBelow) upClr = position;
          end else if (!anyBelow) begin
            nextState = anyAbove ? S_UP : S_IDLE;
            nextUd = anyAbove ? UD_UP : UD_IDLE;
            if (anyAbove) nextLast = UD_UP;
          end
        end
        S_STOP: begin
          // Presses at the open door in the held direction are absorbed
          carClr = position & car_req;
          if (lastDir == UD_UP) upClr = position & up_req;
          else                  dnClr = position & down_req;
          fwd = (lastDir == UD_UP) ? anyAbove : anyBelow;
          back = (lastDir == UD_UP) ? anyBelow : anyAbove;
          if (door_done) begin
            unique case (1'b1)
              fwd: begin
                nextState = (lastDir == UD_UP) ? S_UP : S_DOWN;
                nextUd = lastDir;
              end
              back: begin
                nextState = (lastDir == UD_UP) ? S_DOWN : S_UP;
                nextUd = (lastDir == UD_UP) ? UD_DOWN : UD_UP;
                nextLast = nextUd;
              end
              default: begin
                nextState = S_IDLE;
                nextUd = UD_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    nextEff = '0;
    if (!posOk)                nextEff = effReq;
    else if (nextState == S_UP)   nextEff = allPend & above;
    else if (nextState == S_DOWN) nextEff = allPend & below;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      udMode <= UD_IDLE;
      lastDir <= UD_UP;
      stopHere <= 1'b0;
      effReq <= '0;
      posErr <= 1'b0;
    end else begin
      state <= nextState;
      udMode <= nextUd;
      lastDir <= nextLast;
      stopHere <= (nextState == S_STOP);
      effReq <= nextEff;
      posErr <= !posOk;
    end
  end

  rq_latch #(.FLOORS(FLOORS)) uUp (
    .clk(clk), .rst_n(rst_n),
    .set(up_req & UP_OK), .clr(upClr), .pend(up_pend)
  );

  rq_latch #(.FLOORS(FLOORS)) uDn (
    .clk(clk), .rst_n(rst_n),
    .set(down_req & DN_OK), .clr(dnClr), .pend(down_pend)
  );

  rq_latch #(.FLOORS(FLOORS)) uCar (
    .clk(clk), .rst_n(rst_n),
    .set(car_req), .clr(carClr), .pend(car_pend)
  );

  assign ud_mode = udMode;
  assign stop_here = stopHere;
  assign eff_req = effReq;
  assign pos_err = posErr;

endmodule

// File: tb/tb_rq_scheduler.sv
// Directed-vector bench for rq_scheduler at FLOORS=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_rq_scheduler;

  logic clk, rst_n;
  logic [3:0] upReq, downReq, carReq, position;
  logic doorDone;
  logic [1:0] udMode;
  logic stopHere, posErr;
  logic [3:0] effReq, upPend, downPend, carPend;

  int vecs = 0;
  int errs = 0;

  rq_scheduler #(.FLOORS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_req(upReq), .down_req(downReq), .car_req(carReq),
    .position(position), .door_done(doorDone),
    .ud_mode(udMode), .stop_here(stopHere), .eff_req(effReq),
    .up_pend(upPend), .down_pend(downPend), .car_pend(carPend),
    .pos_err(posErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clrIn();
    upReq = '0;
    downReq = '0;
    carReq = '0;
    doorDone = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clrIn();
    position = 4'b0001;
    step();
    chk("rst_ud", udMode, 2'b00);
    chk("rst_stop", stopHere, 0);
    chk("rst_eff", effReq, 0);
    chk("rst_pend", {upPend, downPend, carPend}, 0);
    chk("rst_perr", posErr, 0);
    rst_n = 1'b1;
    step();

    // car call above ground
    carReq = 4'b0100;
    step(); clrIn();
    chk("t1_carp", carPend, 4'b0100);
    chk("t1_ud0", udMode, 2'b00);
    step();
    chk("t1_ud", udMode, 2'b01);
    chk("t1_eff", effReq, 4'b0100);

    // invalid position while moving up
    position = 4'b0110;
    step();
    chk("t5_perr", posErr, 1);
    chk("t5_ud", udMode, 2'b01);
    chk("t5_carp", carPend, 4'b0100);
    chk("t5_stop", stopHere, 0);
    position = 4'b0100;
    step();
    chk("t5_perr0", posErr, 0);
    chk("t5_srv", stopHere, 1);
    chk("t5_clr", carPend, 4'b0000);
    chk("t5_udh", udMode, 2'b01);
    doorDone = 1'b1;
    step(); clrIn();
    chk("t5_idle", udMode, 2'b00);
    chk("t5_stop0", stopHere, 0);

    // pass a down call going up, reverse at top
    position = 4'b0001;
    step();
    downReq = 4'b0100;
    carReq = 4'b1000;
    step(); clrIn();
    chk("t2_dnp", downPend, 4'b0100);
    chk("t2_carp", carPend, 4'b1000);
    step();
    chk("t2_ud", udMode, 2'b01);
    chk("t2_eff", effReq, 4'b1100);
    position = 4'b0010;
    step();
    chk("t2_f1", stopHere, 0);
    position = 4'b0100;
    step();
    chk("t2_pass", stopHere, 0);
    chk("t2_dnk", downPend, 4'b0100);
    position = 4'b1000;
    step();
    chk("t2_top", stopHere, 1);
    chk("t2_carc", carPend, 4'b0000);
    step();
    chk("t2_hold", stopHere, 1);
    chk("t2_udh", udMode, 2'b01);
    doorDone = 1'b1;
    step(); clrIn();
    chk("t2_rev", udMode, 2'b10);
    chk("t2_s0", stopHere, 0);
    chk("t2_eff2", effReq, 4'b0100);
    position = 4'b0100;
    step();
    chk("t2_f2", stopHere, 1);
    chk("t2_dnc", downPend, 4'b0000);
    chk("t2_ud2", udMode, 2'b10);
    doorDone = 1'b1;
    step(); clrIn();
    chk("t2_idle", udMode, 2'b00);

    // idle with work both ways follows last direction (down)
    carReq = 4'b0001;
    downReq = 4'b1000;
    upReq = 4'b1000;
    step(); clrIn();
    chk("t4_upm", upPend, 4'b0000);
    chk("t4_dnp", downPend, 4'b1000);
    chk("t4_carp", carPend, 4'b0001);
    step();
    chk("t4_ud", udMode, 2'b10);
    chk("t4_eff", effReq, 4'b0001);
    position = 4'b0010;
    step();
    chk("t4_f1", stopHere, 0);
    position = 4'b0001;
    step();
    chk("t4_f0", stopHere, 1);
    chk("t4_carc", carPend, 4'b0000);

    // async reset mid-stop
    rst_n = 1'b0;
    #1;
    chk("t6_ud", udMode, 2'b00);
    chk("t6_stop", stopHere, 0);
    chk("t6_dnp", downPend, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ud2", udMode, 2'b00);
    chk("t6_st2", stopHere, 0);

    // absorb at the open door, bottom down call ignored
    position = 4'b0010;
    carReq = 4'b0010;
    step(); clrIn();
    chk("t3_carp", carPend, 4'b0010);
    step();
    chk("t3_stop", stopHere, 1);
    chk("t3_carc", carPend, 4'b0000);
    chk("t3_ud", udMode, 2'b00);
    upReq = 4'b0010;
    downReq = 4'b0001;
    step(); clrIn();
    chk("t3_abs", upPend, 4'b0000);
    chk("t3_dn0", downPend, 4'b0000);
    chk("t3_held", stopHere, 1);
    doorDone = 1'b1;
    step(); clrIn();
    chk("t3_s0", stopHere, 0);
    chk("t3_idle", udMode, 2'b00);
    doorDone = 1'b1;
    step(); clrIn();
    chk("t3_ddig", {udMode, stopHere}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
